// File: rtl/rr_encoder4x2.sv
// rr_encoder4x2
// Edge-capturing 4-to-2 encoder with round-robin arbitration and a
// valid/ack handshake toward the consumer.
//
// Each request line Di is sampled every cycle. A rising edge that is seen
// while en=1 sets pending[i]. Whenever the presenter is idle and something
// is pending, one pending index is picked round-robin. The picked index is
// presented on {A,B} with valid=1 and held until ack. Acceptance clears the
// pending bit and makes that index the lowest priority for the next pick.
//
// Ports
//   clk      in   1  rising-edge clock
//   rst      in   1  asynchronous active-high reset
//   D0..D3   in   1  request lines (level, sampled on clk)
//   en       in   1  capture enable for new request edges
//   ack      in   1  consumer accepts the presented code
//   A        out  1  code MSB
//   B        out  1  code LSB ({A,B} = index of the presented request)
//   valid    out  1  {A,B} holds a code awaiting ack
//   pending  out  4  captured, not-yet-accepted requests (bit i = Di)

module rr_encoder4x2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       D0,
    input  logic       D1,
    input  logic       D2,
    input  logic       D3,
    input  logic       en,
    input  logic       ack,
    output logic       A,
    output logic       B,
    output logic       valid,
    output logic [3:0] pending
);

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t     state_r;
    logic [3:0] prev_r;
    logic [3:0] pending_r;
    logic [1:0] code_r;
    logic [1:0] last_r;
    logic       valid_r;

    logic [3:0] req_s;
    logic [3:0] rise_s;
    logic [3:0] clr_s;
    logic [3:0] pending_nxt_s;
    logic [1:0] grant_s;

    // Round-robin pick: search last+1, last+2, last+3, then last itself.
    // When nothing is requested the result is don't-care (callers only use
    // it with a non-zero request vector).
    function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] last);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    // Edge detection, acceptance clear and next pending vector.
    always_comb begin
        req_s  = {D3, D2, D1, D0};
        clr_s  = 4'b0000;
        if (en) begin
            rise_s = req_s & ~prev_r;
        end else begin
            rise_s = 4'b0000;
        end
        if ((state_r == SHOW) && ack) begin
            clr_s[code_r] = 1'b1;
        end else begin
            clr_s = 4'b0000;
        end
        // A new edge on the bit being accepted wins over the clear.
        pending_nxt_s = (pending_r & ~clr_s) | rise_s;
        grant_s       = rr_pick(pending_r, last_r);
    end

    // Request capture, arbitration FSM and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_r    <= 4'b0000;
            pending_r <= 4'b0000;
            code_r    <= 2'd0;
            last_r    <= 2'd3;   // D0 gets first priority after reset
            valid_r   <= 1'b0;
            state_r   <= IDLE;
        end else begin
            prev_r    <= req_s;
            pending_r <= pending_nxt_s;
            case (state_r)
                IDLE: begin
                    if (pending_r != 4'b0000) begin
                        code_r  <= grant_s;
                        valid_r <= 1'b1;
                        state_r <= SHOW;
                    end else begin
                        valid_r <= 1'b0;
                    end
                end
                SHOW: begin
                    if (ack) begin
                        last_r  <= code_r;
                        valid_r <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        valid_r <= 1'b1;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign A       = code_r[1];
    assign B       = code_r[0];
    assign valid   = valid_r;
    assign pending = pending_r;

endmodule

// File: tb/tb_rr_encoder4x2.sv
// Directed testbench for rr_encoder4x2. Each task drives one scenario and
// checks the packed observation {valid, A, B, pending} against hand-computed
// values. Inputs change 1 time unit after the rising edge; outputs are
// sampled at that same point, well away from the next active edge.

module tb_rr_encoder4x2;

    logic       clk;
    logic       rst;
    logic [3:0] d;
    logic       en;
    logic       ack;
    logic       A;
    logic       B;
    logic       valid;
    logic [3:0] pending;
    logic [6:0] obs;

    int tests_run    = 0;
    int tests_failed = 0;

    rr_encoder4x2 dut (
        .clk     (clk),
        .rst     (rst),
        .D0      (d[0]),
        .D1      (d[1]),
        .D2      (d[2]),
        .D3      (d[3]),
        .en      (en),
        .ack     (ack),
        .A       (A),
        .B       (B),
        .valid   (valid),
        .pending (pending)
    );

    assign obs = {valid, A, B, pending};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        d   = 4'b0000;
        en  = 1'b1;
        ack = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] exp_tab [3];
        rst = 1'b1; d = 4'b0000; en = 1'b0; ack = 1'b0;
        tick(); tick();
        tests_run++;
        if (obs !== 7'b000_0000) begin
            tests_failed++;
            $display("FAIL reset_state: got %b expected %b", obs, 7'b000_0000);
        end
        // D0 high through reset is captured on the first edge after release.
        d = 4'b0001; en = 1'b1;
        tick();
        rst = 1'b0;
        exp_tab = '{7'b000_0001, 7'b100_0001, 7'b000_0000};
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                ack = 1'b1;
                d   = 4'b0000;
            end
            tick();
            tests_run++;
            if (obs !== exp_tab[i]) begin
                tests_failed++;
                $display("FAIL reset_capture[%0d]: got %b expected %b", i, obs, exp_tab[i]);
            end
        end
        ack = 1'b0;
    endtask

    task automatic test_single();
        logic [6:0] exp_tab [3];
        apply_reset();
        ack = 1'b1;
        d   = 4'b0100;
        exp_tab = '{7'b000_0100, 7'b110_0100, 7'b010_0000};
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (obs !== exp_tab[i]) begin
                tests_failed++;
                $display("FAIL single[%0d]: got %b expected %b", i, obs, exp_tab[i]);
            end
        end
        d = 4'b0000; ack = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [6:0] exp_a [9];
        logic [6:0] exp_b [6];
        apply_reset();
        ack = 1'b1;
        d   = 4'b1111;
        exp_a = '{7'b000_1111, 7'b100_1111, 7'b000_1110, 7'b101_1110, 7'b001_1100,
                  7'b110_1100, 7'b010_1000, 7'b111_1000, 7'b011_0000};
        for (int i = 0; i < 9; i++) begin
            tick();
            tests_run++;
            if (obs !== exp_a[i]) begin
                tests_failed++;
                $display("FAIL rr_all[%0d]: got %b expected %b", i, obs, exp_a[i]);
            end
        end
        // Drop all lines, then re-raise D0 and D3 with last=3: D0 goes first.
        d = 4'b0000;
        exp_b = '{7'b011_0000, 7'b011_1001, 7'b100_1001, 7'b000_1000, 7'b111_1000, 7'b011_0000};
        for (int i = 0; i < 6; i++) begin
            if (i == 1) begin
                d = 4'b1001;
            end
            tick();
            tests_run++;
            if (obs !== exp_b[i]) begin
                tests_failed++;
                $display("FAIL rr_wrap[%0d]: got %b expected %b", i, obs, exp_b[i]);
            end
        end
        d = 4'b0000; ack = 1'b0;
    endtask

    task automatic test_gating();
        apply_reset();
        en  = 1'b0;
        ack = 1'b0;
        d   = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                en = 1'b1;   // D1 still high: no fresh edge to capture
            end
            tick();
            tests_run++;
            if (obs !== 7'b000_0000) begin
                tests_failed++;
                $display("FAIL gating[%0d]: got %b expected %b", i, obs, 7'b000_0000);
            end
        end
        d = 4'b0000;
    endtask

    task automatic test_backpressure();
        logic [6:0] exp_tab [3];
        apply_reset();
        ack = 1'b0;
        d   = 4'b1000;
        tick();
        tick();
        tests_run++;
        if (obs !== 7'b111_1000) begin
            tests_failed++;
            $display("FAIL bp_present: got %b expected %b", obs, 7'b111_1000);
        end
        d = 4'b1010;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                en = 1'b0;   // must not disturb the presented code
            end
            tick();
            tests_run++;
            if (obs !== 7'b111_1010) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: got %b expected %b", i, obs, 7'b111_1010);
            end
        end
        // D1 stays pending with en low and is still presented and accepted.
        ack = 1'b1;
        exp_tab = '{7'b011_0010, 7'b101_0010, 7'b001_0000};
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (obs !== exp_tab[i]) begin
                tests_failed++;
                $display("FAIL bp_after_ack[%0d]: got %b expected %b", i, obs, exp_tab[i]);
            end
        end
        d = 4'b0000; ack = 1'b0; en = 1'b1;
    endtask

    task automatic test_collision();
        logic [6:0] exp_tab [6];
        apply_reset();
        ack = 1'b0;
        d   = 4'b0100;
        exp_tab = '{7'b000_0100, 7'b110_0100, 7'b110_0100,
                    7'b010_0100, 7'b110_0100, 7'b010_0000};
        for (int i = 0; i < 6; i++) begin
            case (i)
                2: d = 4'b0000;
                3: begin d = 4'b0100; ack = 1'b1; end   // re-rise during accept
                4: ack = 1'b0;
                5: begin d = 4'b0000; ack = 1'b1; end
                default: d = d;
            endcase
            tick();
            tests_run++;
            if (obs !== exp_tab[i]) begin
                tests_failed++;
                $display("FAIL collision[%0d]: got %b expected %b", i, obs, exp_tab[i]);
            end
        end
        ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        ack = 1'b0;
        d   = 4'b0110;
        tick();
        tick();
        tests_run++;
        if (obs !== 7'b101_0110) begin
            tests_failed++;
            $display("FAIL rstmid_setup: got %b expected %b", obs, 7'b101_0110);
        end
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (obs !== 7'b000_0000) begin
            tests_failed++;
            $display("FAIL rstmid_async: got %b expected %b", obs, 7'b000_0000);
        end
        #1;
        rst = 1'b0;
        // Lines still high through reset are recaptured on the next edge.
        tick();
        tests_run++;
        if (obs !== 7'b000_0110) begin
            tests_failed++;
            $display("FAIL rstmid_recapture: got %b expected %b", obs, 7'b000_0110);
        end
        d = 4'b0000;
    endtask

    initial begin
        rst = 1'b1;
        d   = 4'b0000;
        en  = 1'b0;
        ack = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_gating();
        test_backpressure();
        test_collision();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
